// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants, event encoding and helpers for the key tracker
package key_pkg;

  // Default number of key inputs on the tracker
  localparam int NUM_KEYS_DEF = 24;

  // Event type bit as stored in the event FIFO
  localparam logic EVT_ON  = 1'b1;
  localparam logic EVT_OFF = 1'b0;

  // Ceiling log2, usable in constant expressions
  function automatic int key_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - synchronous event FIFO with full/empty flags
module evt_fifo
  import key_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int             PTR_W   = key_clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             do_pop;
  logic             do_push;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign do_pop  = ~empty & rd_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign do_push = wr_valid & (~full | do_pop);

  // Advance read and write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Event storage, cleared so the head reads as zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/key_tracker.sv
// rtl/key_tracker.sv - key press tracker with voice allocation, stealing and event FIFO
module key_tracker
  import key_pkg::*;
#(
  parameter int  NUM_KEYS   = NUM_KEYS_DEF,
  parameter int  NUM_VOICES = 4,
  parameter int  EVT_DEPTH  = 8,
  localparam int KEY_W      = key_clog2(NUM_KEYS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         keys,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic                        evt_on,
  output logic [KEY_W-1:0]            evt_key,
  output logic [KEY_W-1:0]            last_key,
  output logic                        last_press,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_KEYS-1:0]         display
);

  localparam int               AGE_W   = (NUM_VOICES > 1) ? key_clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  // Input conditioning
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] prev_q;
  logic [1:0]          warm_q;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;

  // Pending work
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] rel_q, rel_d;
  logic [NUM_KEYS-1:0] clr_press;
  logic [NUM_KEYS-1:0] clr_rel;

  // Voice state
  logic [NUM_VOICES-1:0] vact_q, vact_d;
  logic [KEY_W-1:0]      vkey_q [NUM_VOICES];
  logic [KEY_W-1:0]      vkey_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];
  logic [KEY_W-1:0]      last_key_q, last_key_d;
  logic                  last_press_q, last_press_d;
  logic [NUM_KEYS-1:0]   display_q, display_d;

  // Selection results
  logic rel_any;
  int   rel_idx;
  logic press_any;
  int   press_idx;
  logic free_any;
  int   free_idx;
  int   steal_idx;
  logic hold_hit;
  int   hold_idx;

  // FIFO interface
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             can_push;
  logic             push;
  logic             push_on;
  logic [KEY_W-1:0] push_key;
  logic [KEY_W:0]   fifo_rd_data;

  // Synchronise raw keys and keep the previous synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  // Edge detect, masked until prev holds a real synchronised value so held keys stay quiet
  always_comb begin
    rise = '0;
    fall = '0;
    if (warm_q == 2'd3) begin
      rise = sync2_q & ~prev_q;
      fall = ~sync2_q & prev_q;
    end
  end

  // Pick lowest pending release/press, lowest free voice, oldest voice and the released key's holder
  always_comb begin
    rel_any   = 1'b0;
    rel_idx   = 0;
    press_any = 1'b0;
    press_idx = 0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rel_q[i]) begin
        rel_any = 1'b1;
        rel_idx = i;
      end
      if (press_q[i]) begin
        press_any = 1'b1;
        press_idx = i;
      end
    end
    free_any = 1'b0;
    free_idx = 0;
    hold_hit = 1'b0;
    hold_idx = 0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!vact_q[v]) begin
        free_any = 1'b1;
        free_idx = v;
      end
      if (vact_q[v] && (vkey_q[v] == KEY_W'(rel_idx))) begin
        hold_hit = 1'b1;
        hold_idx = v;
      end
    end
    steal_idx = 0;
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > age_q[steal_idx]) begin
        steal_idx = v;
      end
    end
  end

  assign fifo_pop = ~fifo_empty & evt_ready;
  assign can_push = ~fifo_full | fifo_pop;

  // Service one pending item per cycle, releases first; hold everything while the FIFO is blocked
  always_comb begin
    vact_d     = vact_q;
    vkey_d     = vkey_q;
    age_d      = age_q;
    last_key_d = last_key_q;
    clr_rel    = '0;
    clr_press  = '0;
    push       = 1'b0;
    push_on    = EVT_OFF;
    push_key   = '0;
    if (can_push) begin
      if (rel_any) begin
        clr_rel[rel_idx] = 1'b1;
        if (hold_hit) begin
          vact_d[hold_idx] = 1'b0;
          push             = 1'b1;
          push_on          = EVT_OFF;
          push_key         = KEY_W'(rel_idx);
        end
      end else if (press_any) begin
        if (free_any) begin
          clr_press[press_idx] = 1'b1;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (vact_q[v] && (v != free_idx) && (age_q[v] != AGE_MAX)) begin
              age_d[v] = age_q[v] + AGE_ONE;
            end
          end
          vact_d[free_idx] = 1'b1;
          vkey_d[free_idx] = KEY_W'(press_idx);
          age_d[free_idx]  = '0;
          push             = 1'b1;
          push_on          = EVT_ON;
          push_key         = KEY_W'(press_idx);
          last_key_d       = KEY_W'(press_idx);
        end else begin
          // Steal: the press stays pending and allocates the freed voice next cycle
          vact_d[steal_idx] = 1'b0;
          push              = 1'b1;
          push_on           = EVT_OFF;
          push_key          = vkey_q[steal_idx];
        end
      end
    end
  end

  // Merge new edges into the pend vectors; a release cancels a still-pending press outright
  always_comb begin
    press_d = (press_q & ~clr_press) | rise;
    rel_d   = rel_q & ~clr_rel;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (fall[i]) begin
        if (press_q[i] && !clr_press[i]) begin
          press_d[i] = 1'b0;
          rel_d[i]   = 1'b0;
        end else begin
          rel_d[i] = 1'b1;
        end
      end
    end
  end

  // Display mask follows the next voice state; last_press tracks the synchronised level of last_key
  always_comb begin
    display_d    = '0;
    last_press_d = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (vact_d[v] && (vkey_d[v] == KEY_W'(k))) begin
          display_d[k] = 1'b1;
        end
      end
      if (last_key_q == KEY_W'(k)) begin
        last_press_d = sync2_q[k];
      end
    end
  end

  // Register pend vectors, voices and derived outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q      <= '0;
      rel_q        <= '0;
      vact_q       <= '0;
      last_key_q   <= '0;
      last_press_q <= 1'b0;
      display_q    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      press_q      <= press_d;
      rel_q        <= rel_d;
      vact_q       <= vact_d;
      last_key_q   <= last_key_d;
      last_press_q <= last_press_d;
      display_q    <= display_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey_q[v] <= vkey_d[v];
        age_q[v]  <= age_d[v];
      end
    end
  end

  evt_fifo #(
    .WIDTH (KEY_W + 1),
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (push),
    .wr_data  ({push_on, push_key}),
    .rd_ready (evt_ready),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Pack per-voice keys onto the flat output bus
  always_comb begin
    voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[v*KEY_W +: KEY_W] = vkey_q[v];
    end
  end

  assign evt_valid    = ~fifo_empty;
  assign evt_on       = fifo_rd_data[KEY_W];
  assign evt_key      = fifo_rd_data[KEY_W-1:0];
  assign last_key     = last_key_q;
  assign last_press   = last_press_q;
  assign voice_active = vact_q;
  assign display      = display_q;

endmodule

// File: tb/tb_key_tracker.sv
// tb/tb_key_tracker.sv - scoreboard testbench for key_tracker
module tb_key_tracker;

  localparam int NK = 24;
  localparam int NV = 4;
  localparam int KW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NK-1:0]   keys;
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_on;
  logic [KW-1:0]   evt_key;
  logic [KW-1:0]   last_key;
  logic            last_press;
  logic [NV-1:0]   voice_active;
  logic [NV*KW-1:0] voice_key;
  logic [NK-1:0]   display;

  always #5 clk = ~clk;

  key_tracker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keys         (keys),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_on       (evt_on),
    .evt_key      (evt_key),
    .last_key     (last_key),
    .last_press   (last_press),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .display      (display)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [KW:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_evt(input logic on, input int key);
    exp_q.push_back({on, KW'(key)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NV*KW-1:0] vk(input int k0, input int k1, input int k2, input int k3);
    return {KW'(k3), KW'(k2), KW'(k1), KW'(k0)};
  endfunction

  // Monitor: every accepted event is compared with the head of the expected queue
  initial begin
    logic [KW:0] got;
    logic [KW:0] req;
    forever begin
      @(negedge clk);
      if (rst_n && evt_valid && evt_ready) begin
        got = {evt_on, evt_key};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL evt_unexpected: got on=%0d key=%0d required no event", evt_on, evt_key);
        end else begin
          req = exp_q.pop_front();
          if (got !== req) begin
            n_fail++;
            $display("FAIL evt_order: got on=%0d key=%0d required on=%0d key=%0d",
                     got[KW], got[KW-1:0], req[KW], req[KW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    keys      = '0;
    evt_ready = 1'b0;
    keys[20]  = 1'b1;
    #3;
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_on", evt_on, 0);
    check("rst_evt_key", evt_key, 0);
    check("rst_last_key", last_key, 0);
    check("rst_last_press", last_press, 0);
    check("rst_voice_active", voice_active, 0);
    check("rst_voice_key", voice_key, 0);
    check("rst_display", display, 0);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("held_at_reset_quiet", evt_valid, 0);
    check("held_at_reset_display", display, 0);

    // Single press and release of key 5
    evt_ready = 1'b1;
    keys[5]   = 1'b1;
    expect_evt(1'b1, 5);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (evt_valid) begin
        lat = k;
        break;
      end
    end
    check("latency_edges", lat, 4);
    check("on5_head", {evt_on, evt_key}, {1'b1, 5'd5});
    tick(6);
    check("on5_last_key", last_key, 5);
    check("on5_last_press", last_press, 1);
    check("on5_display", display, 24'h000020);
    check("on5_voice_active", voice_active, 4'b0001);
    check("on5_voice_key", voice_key, vk(5, 0, 0, 0));
    keys[5] = 1'b0;
    expect_evt(1'b0, 5);
    tick(10);
    check("off5_display", display, 0);
    check("off5_voice_active", voice_active, 0);
    check("off5_last_press", last_press, 0);
    check("off5_last_key", last_key, 5);

    // Release of a key that never got a voice emits nothing
    keys[20] = 1'b0;
    tick(10);
    check("rel20_quiet", evt_valid, 0);

    // Keys 3 and 10 together
    keys[3]  = 1'b1;
    keys[10] = 1'b1;
    expect_evt(1'b1, 3);
    expect_evt(1'b1, 10);
    tick(4);
    check("dual_first", {evt_valid, evt_on, evt_key}, {2'b11, 5'd3});
    tick(1);
    check("dual_second", {evt_valid, evt_on, evt_key}, {2'b11, 5'd10});
    tick(6);
    check("dual_display", display, 24'h000408);
    check("dual_voice_key", voice_key, vk(3, 10, 0, 0));
    keys[3]  = 1'b0;
    keys[10] = 1'b0;
    expect_evt(1'b0, 3);
    expect_evt(1'b0, 10);
    tick(10);

    // Fill all voices then steal the oldest
    for (int k = 0; k < 4; k++) begin
      keys[k] = 1'b1;
      expect_evt(1'b1, k);
      tick(8);
    end
    keys[7] = 1'b1;
    expect_evt(1'b0, 0);
    expect_evt(1'b1, 7);
    tick(10);
    check("steal_voice_key", voice_key, vk(7, 1, 2, 3));
    check("steal_voice_active", voice_active, 4'hF);
    check("steal_display", display, 24'h00008E);
    check("steal_last_key", last_key, 7);
    for (int k = 0; k < 4; k++) keys[k] = 1'b0;
    keys[7] = 1'b0;
    expect_evt(1'b0, 1);
    expect_evt(1'b0, 2);
    expect_evt(1'b0, 3);
    expect_evt(1'b0, 7);
    tick(12);
    check("steal_released", voice_active, 0);

    // Nine presses against a blocked consumer
    evt_ready = 1'b0;
    for (int k = 8; k <= 16; k++) keys[k] = 1'b1;
    expect_evt(1'b1, 8);
    expect_evt(1'b1, 9);
    expect_evt(1'b1, 10);
    expect_evt(1'b1, 11);
    expect_evt(1'b0, 8);
    expect_evt(1'b1, 12);
    expect_evt(1'b0, 9);
    expect_evt(1'b1, 13);
    expect_evt(1'b0, 10);
    expect_evt(1'b1, 14);
    expect_evt(1'b0, 11);
    expect_evt(1'b1, 15);
    expect_evt(1'b0, 12);
    expect_evt(1'b1, 16);
    tick(25);
    check("full_head", {evt_valid, evt_on, evt_key}, {2'b11, 5'd8});
    check("full_voice_key", voice_key, vk(12, 13, 10, 11));
    check("full_voice_active", voice_active, 4'hF);
    // One-cycle glitch on key 4 while service is stalled
    keys[4] = 1'b1;
    tick(1);
    keys[4] = 1'b0;
    tick(8);
    check("stall_voice_key", voice_key, vk(12, 13, 10, 11));
    check("stall_head", {evt_on, evt_key}, {1'b1, 5'd8});
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    tick(5);
    check("pop1_head", {evt_valid, evt_on, evt_key}, {2'b11, 5'd9});
    check("pop1_voice_active", voice_active, 4'b1011);
    evt_ready = 1'b1;
    tick(30);
    check("drain_empty", evt_valid, 0);
    check("drain_voice_key", voice_key, vk(16, 13, 14, 15));
    for (int k = 8; k <= 16; k++) keys[k] = 1'b0;
    expect_evt(1'b0, 13);
    expect_evt(1'b0, 14);
    expect_evt(1'b0, 15);
    expect_evt(1'b0, 16);
    tick(15);
    check("drain_released", voice_active, 0);

    // Reset with two voices active
    keys[1] = 1'b1;
    keys[2] = 1'b1;
    expect_evt(1'b1, 1);
    expect_evt(1'b1, 2);
    tick(10);
    check("two_voice_active", voice_active, 4'b0011);
    check("two_display", display, 24'h000006);
    rst_n = 1'b0;
    #1;
    check("async_rst_voice_active", voice_active, 0);
    check("async_rst_voice_key", voice_key, 0);
    check("async_rst_display", display, 0);
    check("async_rst_last", {last_key, last_press}, 0);
    check("async_rst_evt", {evt_valid, evt_on, evt_key}, 0);
    tick(3);
    rst_n = 1'b1;
    tick(12);
    check("post_rst_quiet", evt_valid, 0);
    check("post_rst_voices", voice_active, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
